ofdm_rx_byte_packer: RTL

//  Downstream of the OFDM RX top level. Consumes the 2-bit demapped QPSK bit pairs
//  (rx_rcv_data/rx_rcv_data_valid) and packs four pairs, MSB first, into bytes.

---
 rtl/ofdm_rx_byte_packer_if.sv | 36 +++
 rtl/ofdm_rx_byte_packer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ofdm_rx_byte_packer_if.sv
// -----------------------------------------------------------------------------
// ofdm_rx_byte_packer_if
// Bundles the two streams of the OFDM RX byte packer:
//   - the demapped QPSK bit-pair input (no back-pressure)
//   - the packed byte output (valid/ready handshake)
// Signals:
//   rx_rcv_data        [1:0] demapped bit pair, [1] is the earlier bit
//   rx_rcv_data_valid        pair valid this cycle
//   rx_rcv_data_start        first pair of an OFDM symbol (qualified by valid)
//   byte_data          [7:0] packed byte at the FIFO head
//   byte_valid               byte_data valid
//   byte_ready               sink accepts; transfer on valid & ready
//   byte_sof                 byte_data is the first byte of a symbol
// Modports:
//   master : source of pairs and sink of bytes (the surrounding system)
//   slave  : the byte packer
// -----------------------------------------------------------------------------
interface ofdm_rx_byte_packer_if;
  logic [1:0] rx_rcv_data;
  logic       rx_rcv_data_valid;
  logic       rx_rcv_data_start;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_sof;

  modport master (
    output rx_rcv_data, rx_rcv_data_valid, rx_rcv_data_start, byte_ready,
    input  byte_data, byte_valid, byte_sof
  );

  modport slave (
    input  rx_rcv_data, rx_rcv_data_valid, rx_rcv_data_start, byte_ready,
    output byte_data, byte_valid, byte_sof
  );
endinterface

// File: rtl/ofdm_rx_byte_packer.sv
// -----------------------------------------------------------------------------
// ofdm_rx_byte_packer
// Packs demapped QPSK bit pairs (four per byte, MSB pair first) into bytes that
// are aligned to OFDM symbol starts, buffers them in a byte FIFO and presents
// them on a valid/ready stream with a start-of-symbol flag.
//
// Parameters:
//   fifo_depth_g  byte FIFO depth (power of two, >= 2)
//   cnt_width_g   width of the statistics counters
// Ports:
//   sys_clk   in   system clock, rising edge
//   sys_rst   in   synchronous active-high reset
//   sys_init  in   synchronous re-init pulse, same effect as sys_rst
//   bus       slave modport of ofdm_rx_byte_packer_if (pair input, byte output)
//   overflow  out  sticky: a completed byte was lost because the FIFO was full
//   drop_cnt  out  partial bytes plus overflowed bytes dropped (saturating)
//   byte_cnt  out  bytes accepted by the sink (saturating)
//
// Configuration macro OFDM_RX_BYTE_PACKER_STATS_EN:
//   defined   -> drop_cnt / byte_cnt counters are implemented
//   undefined -> drop_cnt / byte_cnt are tied to zero, no counter registers
// -----------------------------------------------------------------------------
module ofdm_rx_byte_packer #(
  parameter int fifo_depth_g = 16,
  parameter int cnt_width_g  = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   sys_init,
  ofdm_rx_byte_packer_if.slave   bus,
  output logic                   overflow,
  output logic [cnt_width_g-1:0] drop_cnt,
  output logic [cnt_width_g-1:0] byte_cnt
);

  localparam int             AW      = (fifo_depth_g > 1) ? $clog2(fifo_depth_g) : 1;
  localparam logic [AW:0]    C_DEPTH = (AW+1)'(fifo_depth_g);

  typedef enum logic {S_IDLE, S_PACK} state_t;

  logic w_rst;
  assign w_rst = sys_rst | sys_init;

  // Packing FSM
  state_t     r_state, w_state_nxt;
  logic [1:0] r_pair_cnt, w_pair_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_sof, w_sof_nxt;
  logic       w_push;
  logic [8:0] w_push_word;

  always_ff @(posedge sys_clk) begin
    if (w_rst) begin
      r_state    <= S_IDLE;
      r_pair_cnt <= 2'd0;
      r_sof      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pair_cnt <= w_pair_cnt_nxt;
      r_sof      <= w_sof_nxt;
    end
  end

  always_ff @(posedge sys_clk) begin
    r_shift <= w_shift_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pair_cnt_nxt = r_pair_cnt;
    w_shift_nxt    = r_shift;
    w_sof_nxt      = r_sof;
    w_push         = 1'b0;
    w_push_word    = {r_sof, r_shift};
    if (bus.rx_rcv_data_valid) begin
      if (bus.rx_rcv_data_start) begin
        // A start always opens a fresh SOF byte; any partial byte is abandoned.
        w_state_nxt    = S_PACK;
        w_pair_cnt_nxt = 2'd1;
        w_shift_nxt    = {bus.rx_rcv_data, 6'b000000};
        w_sof_nxt      = 1'b1;
      end else if (r_state == S_PACK) begin
        case (r_pair_cnt)
          2'd0: w_shift_nxt = {bus.rx_rcv_data, 6'b000000};
          2'd1: w_shift_nxt = {r_shift[7:6], bus.rx_rcv_data, 4'b0000};
          2'd2: w_shift_nxt = {r_shift[7:4], bus.rx_rcv_data, 2'b00};
          default: begin
            // Fourth pair completes the byte; push it straight from the inputs.
            w_push      = 1'b1;
            w_push_word = {r_sof, r_shift[7:2], bus.rx_rcv_data};
            w_sof_nxt   = 1'b0;
          end
        endcase
        w_pair_cnt_nxt = r_pair_cnt + 2'd1;
      end
    end
  end

  // Byte FIFO with registered first-word-fall-through head
  logic [8:0]    r_mem [fifo_depth_g];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [AW:0]   r_count, w_remain;
  logic          r_byte_valid, r_byte_sof;
  logic [7:0]    r_byte_data;
  logic          r_overflow;
  logic          w_pop, w_full, w_wr_en, w_lost;

  assign w_pop        = r_byte_valid & bus.byte_ready;
  assign w_full       = (r_count == C_DEPTH);
  assign w_wr_en      = w_push & (~w_full | w_pop);
  assign w_lost       = w_push & w_full & ~w_pop;
  assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
  // Entries that stay after this cycle's pop, excluding this cycle's push:
  // a freshly written byte only becomes visible one cycle later (no bypass).
  assign w_remain     = r_count - (AW+1)'(w_pop);

  always_ff @(posedge sys_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_push_word;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_byte_valid <= 1'b0;
      r_byte_sof   <= 1'b0;
      r_byte_data  <= 8'h00;
      r_overflow   <= 1'b0;
    end else begin
      r_wr_ptr     <= r_wr_ptr + AW'(w_wr_en);
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= r_count + (AW+1)'(w_wr_en) - (AW+1)'(w_pop);
      r_byte_valid <= (w_remain != '0);
      r_byte_sof   <= (w_remain != '0) & r_mem[w_rd_ptr_nxt][8];
      if (w_remain != '0) begin
        r_byte_data <= r_mem[w_rd_ptr_nxt][7:0];
      end
      if (w_lost) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.byte_valid = r_byte_valid;
  assign bus.byte_data  = r_byte_data;
  assign bus.byte_sof   = r_byte_sof;
  assign overflow       = r_overflow;

`ifdef OFDM_RX_BYTE_PACKER_STATS_EN
  function automatic logic [cnt_width_g-1:0] sat_inc(input logic [cnt_width_g-1:0] v,
                                                     input logic en);
    if (en && (v != '1)) begin
      return v + {{(cnt_width_g-1){1'b0}}, 1'b1};
    end
    return v;
  endfunction

  logic                   w_drop_partial;
  logic [cnt_width_g-1:0] r_drop_cnt, r_byte_cnt;

  // A start arriving while a byte is partly filled abandons that byte.
  assign w_drop_partial = bus.rx_rcv_data_valid & bus.rx_rcv_data_start &
                          (r_state == S_PACK) & (r_pair_cnt != 2'd0);

  always_ff @(posedge sys_clk) begin
    if (w_rst) begin
      r_drop_cnt <= '0;
      r_byte_cnt <= '0;
    end else begin
      // A partial drop (start pair) and an overflow (fourth pair) never coincide.
      r_drop_cnt <= sat_inc(r_drop_cnt, w_drop_partial | w_lost);
      r_byte_cnt <= sat_inc(r_byte_cnt, w_pop);
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign byte_cnt = r_byte_cnt;
`else
  assign drop_cnt = '0;
  assign byte_cnt = '0;
`endif

endmodule
